jpeg_bit_packer: RTL and testbench

JPEG_BIT_PACKER -- requirements
Module: jpeg_bit_packer

---
 rtl/jpeg_bit_packer_if.sv | 28 ++
 rtl/jpeg_bit_packer.sv | 135 +++++++++++++
 tb/tb_jpeg_bit_packer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_bit_packer_if.sv
// Symbol-in / byte-out bundle for jpeg_bit_packer.
//   master : upstream entropy coder plus downstream byte consumer. Drives the
//            symbols and flush, and observes bytes, ready, flush_done and
//            overflow_err.
//   slave  : the packer itself.
interface jpeg_bit_packer_if;
  logic        sym_valid;
  logic [15:0] sym_code;
  logic [4:0]  sym_len;
  logic [10:0] amp_bits;
  logic [3:0]  amp_len;
  logic        flush;
  logic        sym_ready;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        flush_done;
  logic        overflow_err;

  modport master (
    output sym_valid, sym_code, sym_len, amp_bits, amp_len, flush,
    input  sym_ready, byte_valid, byte_data, flush_done, overflow_err
  );

  modport slave (
    input  sym_valid, sym_code, sym_len, amp_bits, amp_len, flush,
    output sym_ready, byte_valid, byte_data, flush_done, overflow_err
  );
endinterface

// File: rtl/jpeg_bit_packer.sv
// JPEG entropy bit packer.
// Appends a Huffman code and its amplitude bits to a 40-bit MSB-aligned buffer
// and emits the buffer one byte per cycle. Every 0xFF byte is followed by a
// stuffed 0x00. On flush, the partial byte is padded with 1s, and flush_done
// then pulses.
// Ports:
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : jpeg_bit_packer_if.slave, which carries the symbol input, flush,
//             sym_ready, the byte output, flush_done and overflow_err
module jpeg_bit_packer (
  input  logic              clock,
  input  logic              reset_n,
  jpeg_bit_packer_if.slave  bus
);

  typedef enum logic [1:0] {RUN, STUFF, PAD, DONE} state_t;

  state_t      r_state, w_state_n;
  state_t      r_ret,   w_ret_n;     // state to resume after a stuffed 0x00
  logic [39:0] r_buf,   w_buf_n;
  logic [5:0]  r_cnt,   w_cnt_n;
  logic [7:0]  r_hold;               // last emitted byte, shown while idle
  logic        r_ovf;

  logic        w_ready;
  logic        w_emit;
  logic [7:0]  w_byte;
  logic        w_done;
  logic [4:0]  w_sl;
  logic [3:0]  w_al;
  logic [15:0] w_code_m;
  logic [10:0] w_amp_m;
  logic [26:0] w_cat;
  logic [5:0]  w_len;
  logic [39:0] w_ins;
  logic [7:0]  w_pad;

  // Clamp the lengths and mask off the bits above them. Then concatenate
  // code||amplitude, and left-justify the field just below the bits that are
  // already buffered.
  always_comb begin
    w_sl     = (bus.sym_len > 5'd16) ? 5'd16 : bus.sym_len;
    w_al     = (bus.amp_len > 4'd11) ? 4'd11 : bus.amp_len;
    w_code_m = bus.sym_code & ~(16'hFFFF << w_sl);
    w_amp_m  = bus.amp_bits & ~(11'h7FF << w_al);
    w_cat    = ({11'b0, w_code_m} << w_al) | {16'b0, w_amp_m};
    w_len    = {1'b0, w_sl} + {2'b0, w_al};
    w_ins    = ({w_cat, 13'b0} << (6'd27 - w_len)) >> r_cnt;
  end

  // Bits below the top r_cnt positions of r_buf are always zero, so OR-ing
  // in the 1s gives the padded final byte.
  assign w_pad   = r_buf[39:32] | (8'hFF >> r_cnt[2:0]);
  assign w_ready = (r_state == RUN) && (r_cnt < 6'd8) && !bus.flush;

  always_comb begin
    w_state_n = r_state;
    w_ret_n   = r_ret;
    w_buf_n   = r_buf;
    w_cnt_n   = r_cnt;
    w_emit    = 1'b0;
    w_byte    = 8'h00;
    w_done    = 1'b0;
    unique case (r_state)
      RUN: begin
        if (r_cnt >= 6'd8) begin
          w_emit  = 1'b1;
          w_byte  = r_buf[39:32];
          w_buf_n = r_buf << 8;
          w_cnt_n = r_cnt - 6'd8;
          if (r_buf[39:32] == 8'hFF) begin
            w_state_n = STUFF;
            w_ret_n   = RUN;
          end
        end else if (bus.flush) begin
          w_state_n = (r_cnt == 6'd0) ? DONE : PAD;
        end else if (bus.sym_valid) begin
          w_buf_n = r_buf | w_ins;
          w_cnt_n = r_cnt + w_len;
        end
      end
      STUFF: begin
        w_emit    = 1'b1;
        w_byte    = 8'h00;
        w_state_n = r_ret;
      end
      PAD: begin
        w_emit  = 1'b1;
        w_byte  = w_pad;
        w_buf_n = '0;
        w_cnt_n = '0;
        if (w_pad == 8'hFF) begin
          w_state_n = STUFF;
          w_ret_n   = DONE;
        end else begin
          w_state_n = DONE;
        end
      end
      DONE: begin
        w_done    = 1'b1;
        w_state_n = RUN;
      end
      default: w_state_n = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_ret   <= RUN;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ret   <= w_ret_n;
      r_buf   <= w_buf_n;
      r_cnt   <= w_cnt_n;
      if (w_emit) r_hold <= w_byte;
      if (bus.sym_valid && !w_ready) r_ovf <= 1'b1;
    end
  end

  // Outputs follow the state combinationally, so a byte appears in the cycle
  // right after the accept that completes it. Reset masks them, so a pending
  // stuff byte never leaks out while reset is asserted.
  assign bus.sym_ready    = w_ready & reset_n;
  assign bus.byte_valid   = w_emit & reset_n;
  assign bus.byte_data    = bus.byte_valid ? w_byte : r_hold;
  assign bus.flush_done   = w_done & reset_n;
  assign bus.overflow_err = r_ovf;

endmodule

// File: tb/tb_jpeg_bit_packer.sv
module tb_jpeg_bit_packer;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  jpeg_bit_packer_if bus ();

  jpeg_bit_packer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  q[$];

  logic       v_valid, v_ready, v_done, v_ovf;
  logic [7:0] v_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [4:0] sl,
                       input logic [10:0] a, input logic [3:0] al);
    bus.sym_valid = v;
    bus.sym_code  = c;
    bus.sym_len   = sl;
    bus.amp_bits  = a;
    bus.amp_len   = al;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 5'd0, 11'h0, 4'd0);
  endtask

  // One clock cycle: sample at the falling edge, score any byte, then pass the edge.
  task automatic cyc();
    @(negedge clock);
    v_valid = bus.byte_valid;
    v_data  = bus.byte_data;
    v_ready = bus.sym_ready;
    v_done  = bus.flush_done;
    v_ovf   = bus.overflow_err;
    if (v_valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected_byte", {24'b0, v_data}, 32'h100);
      else               chk("byte", {24'b0, v_data}, {24'b0, q.pop_front()});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    do begin
      cyc();
      n++;
    end while (v_done !== 1'b1 && n < 20);
    chk(tag, {31'b0, v_done}, 32'h1);
    bus.flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.flush = 1'b0;
    idle();
    #1;
    cyc();
    cyc();
    chk("rst_valid", {31'b0, v_valid}, 32'h0);
    chk("rst_data",  {24'b0, v_data},  32'h0);
    chk("rst_done",  {31'b0, v_done},  32'h0);
    chk("rst_ovf",   {31'b0, v_ovf},   32'h0);
    chk("rst_ready", {31'b0, v_ready}, 32'h0);
    reset_n = 1'b1;
    cyc();
    chk("ready_after_rst", {31'b0, v_ready}, 32'h1);

    // Two 4-bit codes 1010 combine into 0xAA, emitted one cycle after the second accept.
    drive(1'b1, 16'h000A, 5'd4, 11'h0, 4'd0);
    cyc();
    chk("pack_ready1", {31'b0, v_ready}, 32'h1);
    q.push_back(8'hAA);
    cyc();
    chk("pack_ready2", {31'b0, v_ready}, 32'h1);
    idle();
    cyc();
    chk("pack_latency", {31'b0, v_valid}, 32'h1);
    cyc();
    chk("pack_single", {31'b0, v_valid}, 32'h0);
    chk("pack_hold",   {24'b0, v_data},  32'hAA);
    chk("pack_ready3", {31'b0, v_ready}, 32'h1);

    // Byte stuffing: 0xFF is followed by 0x00, and ready stays low through both.
    drive(1'b1, 16'h00FF, 5'd8, 11'h0, 4'd0);
    q.push_back(8'hFF);
    q.push_back(8'h00);
    cyc();
    idle();
    cyc();
    chk("stuff_ff_valid", {31'b0, v_valid}, 32'h1);
    chk("stuff_ff_ready", {31'b0, v_ready}, 32'h0);
    cyc();
    chk("stuff_00_valid", {31'b0, v_valid}, 32'h1);
    chk("stuff_00_ready", {31'b0, v_ready}, 32'h0);
    cyc();
    chk("stuff_resume", {31'b0, v_ready}, 32'h1);

    // Flush with three bits 101 pending: padded to 0xBF, then flush_done.
    drive(1'b1, 16'h0005, 5'd3, 11'h0, 4'd0);
    q.push_back(8'hBF);
    cyc();
    idle();
    bus.flush = 1'b1;
    cyc();
    chk("flush_ready", {31'b0, v_ready}, 32'h0);
    wait_done("flush_done_pad");
    cyc();
    chk("flush_done_pulse", {31'b0, v_done}, 32'h0);

    // Flush with an empty buffer produces flush_done and no byte.
    bus.flush = 1'b1;
    wait_done("flush_done_empty");
    cyc();

    // Clamping and masking of ignored upper bits:
    // 1010 + 101, then an empty symbol, then code 1 => 0xAB.
    drive(1'b1, 16'hFF0A, 5'd4, 11'h7F5, 4'd3);
    cyc();
    drive(1'b1, 16'hFFFF, 5'd0, 11'h7FF, 4'd0);
    cyc();
    drive(1'b1, 16'hFFF1, 5'd1, 11'h0, 4'd0);
    q.push_back(8'hAB);
    cyc();
    idle();
    cyc();
    chk("mask_valid", {31'b0, v_valid}, 32'h1);
    cyc();

    // 27-bit worst case (lengths clamped to 16+11). A symbol offered while
    // bytes are being emitted is dropped and sets overflow_err.
    drive(1'b1, 16'hFFFF, 5'd20, 11'h000, 4'd15);
    q.push_back(8'hFF); q.push_back(8'h00);
    q.push_back(8'hFF); q.push_back(8'h00);
    q.push_back(8'h00);
    cyc();
    drive(1'b1, 16'h00FF, 5'd8, 11'h0, 4'd0);
    cyc();
    chk("ovf_ready", {31'b0, v_ready}, 32'h0);
    idle();
    for (int i = 0; i < 5; i++) cyc();
    chk("ovf_sticky", {31'b0, v_ovf}, 32'h1);
    chk("worst_drained", q.size(), 32'h0);
    q.push_back(8'h1F);
    bus.flush = 1'b1;
    wait_done("flush_done_worst");
    chk("ovf_sticky2", {31'b0, v_ovf}, 32'h1);

    // A padded byte that comes out as 0xFF is stuffed before flush_done.
    drive(1'b1, 16'h007F, 5'd7, 11'h0, 4'd0);
    q.push_back(8'hFF);
    q.push_back(8'h00);
    cyc();
    idle();
    bus.flush = 1'b1;
    wait_done("flush_done_padff");
    cyc();

    // Reset in the cycle after a 0xFF: the stuffed 0x00 must not appear.
    drive(1'b1, 16'h00FF, 5'd8, 11'h0, 4'd0);
    q.push_back(8'hFF);
    cyc();
    idle();
    cyc();
    chk("rst_stuff_ff", {31'b0, v_valid}, 32'h1);
    reset_n = 1'b0;
    cyc();
    chk("rst_stuff_no00", {31'b0, v_valid}, 32'h0);
    reset_n = 1'b1;
    cyc();
    chk("rst_stuff_novalid", {31'b0, v_valid}, 32'h0);
    chk("rst_stuff_ready",   {31'b0, v_ready}, 32'h1);
    chk("rst_clears_ovf",    {31'b0, v_ovf},   32'h0);
    bus.flush = 1'b1;
    wait_done("flush_done_after_rst");
    cyc();
    cyc();
    chk("queue_empty", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
